// File: rtl/acumulador_sat_pkg.sv
// Shared fixed-point constants for the accumulation chain.
// Default Q(M.F) format, block length and accumulator sizing helper.
package acumulador_sat_pkg;

    // Q(M.F) sample format: N = 1 + M + F
    localparam int N_DEF     = 16;
    localparam int M_DEF     = 7;
    localparam int F_DEF     = 8;

    // samples summed per block
    localparam int LARGO_DEF = 16;

    // double-width samples plus growth bits for LARGO additions
    function automatic int ancho_acum(input int n, input int largo);
        return 2 * n + $clog2(largo);
    endfunction

endpackage

// File: rtl/acumulador_sat_saturar.sv
// Shift-and-saturate: accumulator with 2F fraction bits to Q(M.F).
// Floor shift by F, then clip to the N-bit signed range.
module saturar #(
    parameter int W = 40,
    parameter int M = 7,
    parameter int F = 8
) (
    input  logic signed [W-1:0] acum,
    output logic signed [M+F:0] valor,
    output logic                sat
);

    localparam int N = 1 + M + F;

    localparam logic signed [N-1:0] VMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] VMIN = {1'b1, {(N-1){1'b0}}};

    logic signed [W-1:0] desp;
    logic        [W-N:0] alto;

    // arithmetic shift rounds toward minus infinity
    assign desp = acum >>> F;
    assign alto = desp[W-1:N-1];

    // fits in N bits only when all bits from the sign down are equal
    always_comb begin
        valor = desp[N-1:0];
        sat   = 1'b0;
        if (!(&alto) && (|alto)) begin
            sat   = 1'b1;
            valor = desp[W-1] ? VMIN : VMAX;
        end
    end

endmodule

// File: rtl/acumulador_sat.sv
// Block accumulator: sums LARGO double-width samples, then converts
// the total to a saturated Q(M.F) result with a one-cycle listo pulse.
module acumulador_sat
    import acumulador_sat_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int F     = F_DEF,
    parameter int LARGO = LARGO_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic signed [2*N-1:0] dato_in,
    input  logic                  dato_valido,
    output logic signed [N-1:0]   resultado,
    output logic                  listo,
    output logic                  ocupado,
    output logic                  saturado
);

    localparam int AW = ancho_acum(N, LARGO);
    localparam int CW = $clog2(LARGO + 1);

    localparam logic [CW-1:0] ULTIMO = CW'(LARGO - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACUM,
        CONVERTIR
    } estado_t;

    estado_t               estado;
    logic signed [AW-1:0]  acum;
    logic        [CW-1:0]  cuenta;
    logic signed [AW-1:0]  dato_ext;
    logic signed [N-1:0]   valor_sat;
    logic                  flag_sat;

    assign dato_ext = {{(AW-2*N){dato_in[2*N-1]}}, dato_in};

    saturar #(
        .W (AW),
        .M (M),
        .F (F)
    ) u_saturar (
        .acum  (acum),
        .valor (valor_sat),
        .sat   (flag_sat)
    );

    // control FSM with accumulator, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            acum      <= '0;
            cuenta    <= '0;
            resultado <= '0;
            saturado  <= 1'b0;
            listo     <= 1'b0;
        end else begin
            listo <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (inicio) begin
                        acum   <= '0;
                        cuenta <= '0;
                        estado <= ACUM;
                    end
                end
                ACUM: begin
                    if (dato_valido) begin
                        acum   <= acum + dato_ext;
                        cuenta <= cuenta + CW'(1);
                        if (cuenta == ULTIMO)
                            estado <= CONVERTIR;
                    end
                end
                CONVERTIR: begin
                    resultado <= valor_sat;
                    saturado  <= flag_sat;
                    listo     <= 1'b1;
                    estado    <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign ocupado = (estado != IDLE);

endmodule

// File: tb/tb_acumulador_sat.sv
// Scoreboard bench for acumulador_sat with directed and random blocks.
// Expected results come from an integer model of the block sum.
module tb_acumulador_sat;

    localparam int N     = 16;
    localparam int M     = 7;
    localparam int F     = 8;
    localparam int LARGO = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  inicio;
    logic signed [2*N-1:0] dato_in;
    logic                  dato_valido;
    logic signed [N-1:0]   resultado;
    logic                  listo;
    logic                  ocupado;
    logic                  saturado;

    acumulador_sat #(
        .N     (N),
        .M     (M),
        .F     (F),
        .LARGO (LARGO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inicio      (inicio),
        .dato_in     (dato_in),
        .dato_valido (dato_valido),
        .resultado   (resultado),
        .listo       (listo),
        .ocupado     (ocupado),
        .saturado    (saturado)
    );

    always #5 clk = ~clk;

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          ciclo;
    } esp_t;

    esp_t cola[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit    activo   = 1'b0;
    int    n_mod    = 0;
    longint suma    = 0;
    int    fin_edge = -100;

    function automatic esp_t referencia(input longint s, input int c);
        esp_t   r;
        longint d;
        d       = s >>> F;
        r.ciclo = c;
        if (d > 32767) begin
            r.res = 16'h7FFF;
            r.sat = 1'b1;
        end else if (d < -32768) begin
            r.res = 16'h8000;
            r.sat = 1'b1;
        end else begin
            r.res = d[15:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

    task automatic paso(input bit ini, input bit val, input logic [31:0] d);
        int e;
        inicio      = ini;
        dato_valido = val;
        dato_in     = d;
        @(posedge clk);
        #1;
        e = ciclo;
        if (!activo) begin
            if (ini && e >= fin_edge + 2) begin
                activo = 1'b1;
                suma   = 0;
                n_mod  = 0;
            end
        end else if (val) begin
            suma  = suma + longint'($signed(d));
            n_mod = n_mod + 1;
            if (n_mod == LARGO) begin
                cola.push_back(referencia(suma, e + 1));
                activo   = 1'b0;
                fin_edge = e;
            end
        end
        inicio      = 1'b0;
        dato_valido = 1'b0;
    endtask

    task automatic esperar_listo(input string nombre, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (listo) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: listo=%b required=1", nombre, listo);
        end
    endtask

    task automatic chequear(input string nombre, input logic [15:0] r,
                            input logic s);
        bit ok;
        esperar_listo(nombre, ok);
        if (ok) begin
            checks++;
            if (resultado !== r || saturado !== s || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL %s: resultado=%h saturado=%b ocupado=%b required %h %b 0",
                         nombre, resultado, saturado, ocupado, r, s);
            end
        end
    endtask

    task automatic bloque(input logic [31:0] d, input bit alterna,
                          input bit ini_medio);
        int i;
        bit t;
        i = 0;
        t = 1'b0;
        paso(1'b1, 1'b0, 32'h0);
        while (i < LARGO) begin
            if (alterna && t) begin
                paso(ini_medio && i == 8, 1'b0, d);
            end else begin
                paso(ini_medio && i == 8, 1'b1, d);
                i++;
            end
            t = ~t;
        end
    endtask

    task automatic check_cero(input string nombre);
        checks++;
        if (resultado !== '0 || saturado !== 1'b0 || listo !== 1'b0 ||
            ocupado !== 1'b0) begin
            errors++;
            $display("FAIL %s: res=%h sat=%b listo=%b ocup=%b required all 0",
                     nombre, resultado, saturado, listo, ocupado);
        end
    endtask

    // monitor: every listo pops one expected result
    bit   listo_prev = 1'b0;
    esp_t x;
    always @(negedge clk) begin
        if (reset) begin
            if (listo) begin
                checks++;
                if (listo_prev) begin
                    errors++;
                    $display("FAIL listo_ancho: listo high 2 cycles, required 1");
                end
                if (cola.size() == 0) begin
                    errors++;
                    $display("FAIL listo_inesperado: listo=1 required 0 at ciclo %0d",
                             ciclo);
                end else begin
                    x = cola.pop_front();
                    if (resultado !== x.res || saturado !== x.sat ||
                        ciclo != x.ciclo) begin
                        errors++;
                        $display("FAIL scoreboard: res=%h sat=%b ciclo=%0d required %h %b %0d",
                                 resultado, saturado, ciclo, x.res, x.sat, x.ciclo);
                    end
                end
            end
            listo_prev = listo;
        end else begin
            listo_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        bit          ok;
        int          lim;

        reset       = 1'b0;
        inicio      = 1'b0;
        dato_valido = 1'b0;
        dato_in     = '0;
        #3;
        check_cero("reset_inicial");
        #10;
        reset = 1'b1;
        paso(1'b0, 1'b0, 32'h0);

        // samples without inicio are ignored
        repeat (LARGO + 2) paso(1'b0, 1'b1, 32'h0001_0000);
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL sin_inicio: ocupado=%b required 0", ocupado);
        end

        bloque(32'h0001_0000, 1'b0, 1'b0);
        chequear("t1_uno", 16'h1000, 1'b0);

        bloque(32'hFFFF_0000, 1'b0, 1'b0);
        chequear("t2_menos_uno", 16'hF000, 1'b0);

        bloque(32'h0064_0000, 1'b0, 1'b0);
        chequear("t3_sat_pos", 16'h7FFF, 1'b1);

        bloque(32'hFF9C_0000, 1'b0, 1'b0);
        chequear("t3_sat_neg", 16'h8000, 1'b1);

        bloque(32'h0001_0000, 1'b1, 1'b1);
        chequear("t4_alterna", 16'h1000, 1'b0);

        // abort after 8 samples
        paso(1'b1, 1'b0, 32'h0);
        repeat (8) paso(1'b0, 1'b1, 32'h0001_0000);
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL ocupado_acum: ocupado=%b required 1", ocupado);
        end
        #2;
        reset = 1'b0;
        #1;
        check_cero("t5_reset_abort");
        activo   = 1'b0;
        fin_edge = -100;
        cola.delete();
        #2;
        reset = 1'b1;
        repeat (LARGO) paso(1'b0, 1'b1, 32'h0001_0000);
        check_cero("t5_tras_reset");
        bloque(32'h0001_0000, 1'b0, 1'b0);
        chequear("t5_nuevo", 16'h1000, 1'b0);

        // back-to-back: inicio in the listo cycle
        bloque(32'h0001_0000, 1'b0, 1'b0);
        paso(1'b0, 1'b0, 32'h0);
        checks++;
        if (listo !== 1'b1 || resultado !== 16'h1000) begin
            errors++;
            $display("FAIL t6_primero: listo=%b res=%h required 1 1000",
                     listo, resultado);
        end
        paso(1'b1, 1'b1, 32'h0000_8000);
        repeat (LARGO) paso(1'b0, 1'b1, 32'h0000_8000);
        chequear("t6_segundo", 16'h0800, 1'b0);

        // random blocks
        for (int b = 0; b < 30; b++) begin
            lim = 0;
            while (!activo && lim < 10) begin
                r = $urandom;
                paso(1'b1, $urandom_range(0, 1) == 1,
                     $signed(r) >>> $urandom_range(0, 24));
                lim++;
            end
            lim = 0;
            while (activo && lim < 200) begin
                r = $urandom;
                paso($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                     $signed(r) >>> $urandom_range(0, 24));
                lim++;
            end
            repeat ($urandom_range(0, 3)) paso(1'b0, $urandom_range(0, 1) == 1,
                                              $urandom);
        end
        repeat (5) paso(1'b0, 1'b0, 32'h0);

        checks++;
        if (cola.size() != 0) begin
            errors++;
            $display("FAIL cola_vacia: pending=%0d required 0", cola.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acumulador_sat.md
ACUMULADOR_SAT -- requirements
Module: acumulador_sat

Interface
REQ-001 The block SHALL use parameters N, M, F: defaults from constantes.h; Q(M.F) sample width, integer bits, fraction bits, with N = 1+M+F.
REQ-002 The block SHALL use parameter LARGO: default 16; number of samples summed per block, 2..256.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port inicio SHALL be an input, 1 bit: start pulse for a new block.
REQ-006 Port dato_in SHALL be an input, signed, 2N bits: double-width sample with 2F fraction bits, as produced by the upstream widening stage.
REQ-007 Port dato_valido SHALL be an input, 1 bit: dato_in is valid this cycle.
REQ-008 Port resultado SHALL be an output, signed, N bits: saturated Q(M.F) sum.
REQ-009 Port listo SHALL be an output, 1 bit: one-cycle pulse, resultado updated.
REQ-010 Port ocupado SHALL be an output, 1 bit: high while not in IDLE.
REQ-011 Port saturado SHALL be an output, 1 bit: last result was clipped, valid with listo and held afterwards.

Function
REQ-012 The block SHALL implement the states IDLE, ACUM and CONVERTIR.
REQ-013 In IDLE, inicio=1 SHALL, at that edge, clear the accumulator, clear the counter, and go to ACUM.
REQ-014 In ACUM, each cycle with dato_valido=1 SHALL add dato_in, sign-extended, to the accumulator and increment the counter.
REQ-015 In ACUM, cycles with dato_valido=0 SHALL hold all state.
REQ-016 Acceptance of the LARGO-th sample SHALL move the block to CONVERTIR.
REQ-017 The accumulator SHALL be 2N+clog2(LARGO) bits wide, so that no intermediate overflow is possible.
REQ-018 CONVERTIR SHALL take an arithmetic right shift of the accumulator by F, truncating toward minus infinity.
REQ-019 CONVERTIR SHALL saturate the shifted value to [-2^(N-1), 2^(N-1)-1].
REQ-020 At the edge leaving CONVERTIR, the block SHALL register resultado and saturado, pulse listo high for exactly the next cycle, and return to IDLE.
REQ-021 Latency SHALL be: listo is high in the second cycle after the edge that accepts the last sample.
REQ-022 inicio SHALL be ignored in ACUM and CONVERTIR.
REQ-023 inicio SHALL be honoured in the IDLE cycle in which listo is high, giving back-to-back blocks.
REQ-024 dato_valido SHALL be ignored in IDLE and CONVERTIR; no sample is accepted or stored.
REQ-025 resultado and saturado SHALL hold their values until the next listo.
REQ-026 When dato_valido and inicio are both high in IDLE, only the start SHALL take effect; the sample is not accumulated.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, accumulator 0, counter 0, resultado 0, listo 0, saturado 0, ocupado 0.
REQ-028 A reset during ACUM or CONVERTIR SHALL abort the block with no listo pulse.
REQ-029 After deassertion of reset, the block SHALL require a new inicio.

Structure
REQ-030 N, M, F SHALL come from the shared constantes.h.
REQ-031 Saturation limits and the state encoding SHALL be local to the module.
REQ-032 The shift-and-saturate logic SHALL be one combinational sub-module, saturar (accumulator in, N-bit value and flag out), reused by later stages.

Verification (N=16, M=7, F=8, LARGO=16)
REQ-033 Test 1: inicio, then 16 valid samples of 0x00010000 (1.0) -> resultado=0x1000, saturado=0, listo is exactly one cycle, 2 cycles after the last sample.
REQ-034 Test 2: 16 samples of 0xFFFF0000 (-1.0) -> resultado=0xF000, saturado=0.
REQ-035 Test 3: 16 samples of 0x00640000 (100.0) -> resultado=0x7FFF, saturado=1; 16 samples of 0xFF9C0000 (-100.0) -> resultado=0x8000, saturado=1.
REQ-036 Test 4: 16 samples of 1.0 with dato_valido toggling every other cycle, and inicio pulsed mid-block -> resultado=0x1000, ignored inicio has no effect.
REQ-037 Test 5: reset=0 after 8 samples -> outputs zero immediately, no listo; a new 16-sample block of 1.0 -> 0x1000.
REQ-038 Test 6: inicio during the listo cycle, then 16 samples of 0x00008000 (0.5) -> two consecutive results 0x1000 then 0x0800, no lost sample.
